// File: rtl/hazard_scoreboard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_ctrl
//
// Hazard controller for a 5-stage RV32 pipeline with branches resolved in ID.
// Outstanding loads are tracked per destination register by a small countdown.
// An instruction in ID stalls while any register it reads is still too far
// from being forwardable. Consumers that need operands in ID (branches, JALR)
// must wait one cycle longer than ALU consumers.
// A taken branch flushes IF/ID for BR_PENALTY cycles. A D-cache busy freezes
// the whole pipeline, including every internal counter.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   id_valid          ID stage holds a real instruction
//   id_op             ID opcode
//   id_rs1, id_rs2    ID source registers
//   id_use_rs2        ID instruction reads rs2
//   id_rd             ID destination register
//   id_is_load        ID instruction is a load
//   br_taken          branch/jump in ID resolved taken
//   mem_busy          D-cache not ready
//   stall_all         freeze every pipeline register and the PC
//   stall_if_id       hold PC and IF/ID
//   bubble_id_ex      insert a NOP into ID/EX
//   flush_if_id       insert a NOP into IF/ID
//   perf_stall_cnt    saturating count of cycles with stall_all | stall_if_id
//
// Handshake note: there is no valid/ready pairing here. id_valid qualifies the
// ID fields in the same cycle. An instruction "issues" (leaves ID) in any cycle
// where it is valid, not squashed, not data-stalled and the cache is not busy.
// -----------------------------------------------------------------------------
module hazard_scoreboard_ctrl #(
   parameter int          NREG       = 32,
   parameter int          RAW        = 5,
   parameter int          LOAD_LAT   = 2,
   parameter int          BR_PENALTY = 1,
   parameter int          PERF_W     = 32,
   parameter logic [6:0]  OP_BRANCH  = 7'b1100011,
   parameter logic [6:0]  OP_JALR    = 7'b1100111
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [6:0]        id_op,
   input  logic [RAW-1:0]    id_rs1,
   input  logic [RAW-1:0]    id_rs2,
   input  logic              id_use_rs2,
   input  logic [RAW-1:0]    id_rd,
   input  logic              id_is_load,
   input  logic              br_taken,
   input  logic              mem_busy,
   output logic              stall_all,
   output logic              stall_if_id,
   output logic              bubble_id_ex,
   output logic              flush_if_id,
   output logic [PERF_W-1:0] perf_stall_cnt
);

   localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT);
   localparam logic [2:0] ALU_NEED = 3'(LOAD_LAT - 1);
   localparam logic [1:0] FL_INIT  = 2'(BR_PENALTY - 1);

   logic [2:0]        cnt_q [NREG];
   logic [2:0]        cnt_d [NREG];
   logic [1:0]        fl_cnt_q, fl_cnt_d;
   logic [PERF_W-1:0] perf_q, perf_d;

   logic       squash;
   logic       ctrl_op;
   logic [2:0] need;
   logic       hit_rs1, hit_rs2;
   logic       data_stall;
   logic       issue;
   logic       br_honoured;

   // Hazard detection. A register is "hit" while its countdown exceeds the
   // number of cycles this consumer can still tolerate before it needs data.
   always_comb begin
      squash      = (fl_cnt_q != 2'd0);
      ctrl_op     = (id_op == OP_BRANCH) || (id_op == OP_JALR);
      need        = ctrl_op ? 3'd0 : ALU_NEED;
      hit_rs1     = (id_rs1 != '0) && (cnt_q[id_rs1] > need);
      hit_rs2     = (id_rs2 != '0) && (cnt_q[id_rs2] > need);
      data_stall  = id_valid && !squash && (hit_rs1 || (id_use_rs2 && hit_rs2));
      issue       = rst_n && id_valid && !squash && !data_stall && !mem_busy;
      br_honoured = issue && br_taken;
   end

   // Outputs: cache busy dominates, then data stall, then flush. Everything
   // is forced low while reset is held, independent of the other inputs.
   always_comb begin
      stall_all    = rst_n && mem_busy;
      stall_if_id  = rst_n && !mem_busy && data_stall;
      bubble_id_ex = rst_n && !mem_busy && data_stall;
      flush_if_id  = rst_n && !mem_busy && !data_stall && (br_honoured || squash);
   end

   // Scoreboard and flush counter next state. While the cache is busy all
   // state holds. A load setting its destination wins over that entry's
   // own decrement in the same cycle.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
      end
      fl_cnt_d = fl_cnt_q;
      if (!mem_busy) begin
         for (int r = 1; r < NREG; r++) begin
            if (issue && id_is_load && (id_rd == RAW'(r))) begin
               cnt_d[r] = LAT_INIT;
            end else if (cnt_q[r] != 3'd0) begin
               cnt_d[r] = cnt_q[r] - 3'd1;
            end
         end
         if (br_honoured) begin
            fl_cnt_d = FL_INIT;
         end else if (squash) begin
            fl_cnt_d = fl_cnt_q - 2'd1;
         end
      end
      cnt_d[0] = 3'd0;
   end

   always_comb begin
      perf_d = perf_q;
      if ((stall_all || stall_if_id) && (perf_q != {PERF_W{1'b1}})) begin
         perf_d = perf_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= 3'd0;
         end
         fl_cnt_q <= 2'd0;
         perf_q   <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         fl_cnt_q <= fl_cnt_d;
         perf_q   <= perf_d;
      end
   end

   assign perf_stall_cnt = perf_q;

endmodule
